// File: rtl/pred_reg_arbiter.sv
// Round-robin arbiter sharing one predicate register block among NUM_REQ requesters.
// Optional macro PRED_ARB_WRITE_PRIO_EN: pending writes win over reads; rr_ptr advances on read grants only.
module pred_reg_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int LANES     = 16,
  parameter  int NUM_WARPS = 8,
  parameter  int NUM_PREGS = 32,
  localparam int WW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int AW        = (NUM_PREGS > 1) ? $clog2(NUM_PREGS) : 1,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_is_write,
  input  logic [NUM_REQ*WW-1:0]    req_warp,
  input  logic [NUM_REQ*AW-1:0]    req_raddr_0,
  input  logic [NUM_REQ*AW-1:0]    req_raddr_1,
  input  logic [NUM_REQ*AW-1:0]    req_waddr,
  input  logic [NUM_REQ*LANES-1:0] req_lane_mask,
  input  logic [NUM_REQ*LANES-1:0] req_wdata,
  output logic [WW-1:0]            warp_selector,
  output logic [LANES-1:0]         read_en_0,
  output logic [LANES-1:0]         read_en_1,
  output logic [AW-1:0]            raddr_0,
  output logic [AW-1:0]            raddr_1,
  output logic [LANES-1:0]         write_en,
  output logic [AW-1:0]            waddr,
  output logic [LANES-1:0]         wdata,
  input  logic [LANES-1:0]         rdata_0,
  input  logic [LANES-1:0]         rdata_1,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [LANES-1:0]         rsp_rdata_0,
  output logic [LANES-1:0]         rsp_rdata_1
);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     nxt_ptr;
  logic [NUM_REQ-1:0] cand;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic               ptr_upd;

  logic               sel_wr;
  logic [WW-1:0]      sel_warp;
  logic [AW-1:0]      sel_raddr_0;
  logic [AW-1:0]      sel_raddr_1;
  logic [AW-1:0]      sel_waddr;
  logic [LANES-1:0]   sel_mask;
  logic [LANES-1:0]   sel_wdata;

  logic               rd_vld_p0;
  logic [IDW-1:0]     id_p0;

`ifdef PRED_ARB_WRITE_PRIO_EN
  logic [NUM_REQ-1:0] wr_req;
  assign wr_req  = req_valid & req_is_write;
  assign cand    = (|wr_req) ? wr_req : req_valid;
  assign ptr_upd = gnt_any && !sel_wr;
`else
  assign cand    = req_valid;
  assign ptr_upd = gnt_any;
`endif

  // Arbitration: first candidate at or after rr_ptr, then wrap to the lower indices
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && !gnt_any && cand[i] && (i >= int'(rr_ptr))) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && !gnt_any && cand[i] && (i < int'(rr_ptr))) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign nxt_ptr = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    sel_wr      = 1'b0;
    sel_warp    = '0;
    sel_raddr_0 = '0;
    sel_raddr_1 = '0;
    sel_waddr   = '0;
    sel_mask    = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_wr      = req_is_write[i];
        sel_warp    = req_warp[i*WW +: WW];
        sel_raddr_0 = req_raddr_0[i*AW +: AW];
        sel_raddr_1 = req_raddr_1[i*AW +: AW];
        sel_waddr   = req_waddr[i*AW +: AW];
        sel_mask    = req_lane_mask[i*LANES +: LANES];
        sel_wdata   = req_wdata[i*LANES +: LANES];
      end
    end
  end

  // Stage p0: issue registers drive the block; addresses/warp/wdata hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      warp_selector <= '0;
      raddr_0       <= '0;
      raddr_1       <= '0;
      waddr         <= '0;
      wdata         <= '0;
      read_en_0     <= '0;
      read_en_1     <= '0;
      write_en      <= '0;
      rd_vld_p0     <= 1'b0;
      id_p0         <= '0;
    end else begin
      if (ptr_upd) rr_ptr <= nxt_ptr;
      if (gnt_any) begin
        warp_selector <= sel_warp;
        raddr_0       <= sel_raddr_0;
        raddr_1       <= sel_raddr_1;
        waddr         <= sel_waddr;
        wdata         <= sel_wdata;
        id_p0         <= gnt_id;
      end
      read_en_0 <= (gnt_any && !sel_wr) ? sel_mask : '0;
      read_en_1 <= (gnt_any && !sel_wr) ? sel_mask : '0;
      write_en  <= (gnt_any && sel_wr) ? sel_mask : '0;
      rd_vld_p0 <= gnt_any && !sel_wr;
    end
  end

  // Stage p1: capture combinational block read data, masked by the issued enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata_0 <= '0;
      rsp_rdata_1 <= '0;
    end else begin
      rsp_valid <= rd_vld_p0;
      if (rd_vld_p0) begin
        rsp_id      <= id_p0;
        rsp_rdata_0 <= rdata_0 & read_en_0;
        rsp_rdata_1 <= rdata_1 & read_en_1;
      end
    end
  end

endmodule

// File: tb/tb_pred_reg_arbiter.sv
// Directed bench for pred_reg_arbiter with a behavioural predicate register block.
module tb_pred_reg_arbiter;
  localparam int NUM_REQ = 4;
  localparam int LANES   = 16;
  localparam int NW      = 8;
  localparam int NP      = 32;
  localparam int WW      = 3;
  localparam int AW      = 5;
  localparam int IDW     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_is_write = '0;
  logic [NUM_REQ*WW-1:0]    req_warp = '0;
  logic [NUM_REQ*AW-1:0]    req_raddr_0 = '0;
  logic [NUM_REQ*AW-1:0]    req_raddr_1 = '0;
  logic [NUM_REQ*AW-1:0]    req_waddr = '0;
  logic [NUM_REQ*LANES-1:0] req_lane_mask = '0;
  logic [NUM_REQ*LANES-1:0] req_wdata = '0;
  logic [WW-1:0]            warp_selector;
  logic [LANES-1:0]         read_en_0, read_en_1, write_en, wdata;
  logic [AW-1:0]            raddr_0, raddr_1, waddr;
  logic [LANES-1:0]         rdata_0, rdata_1;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [LANES-1:0]         rsp_rdata_0, rsp_rdata_1;

  int n_vec = 0;
  int n_err = 0;

  pred_reg_arbiter #(.NUM_REQ(NUM_REQ), .LANES(LANES), .NUM_WARPS(NW), .NUM_PREGS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_warp(req_warp), .req_raddr_0(req_raddr_0), .req_raddr_1(req_raddr_1),
    .req_waddr(req_waddr), .req_lane_mask(req_lane_mask), .req_wdata(req_wdata),
    .warp_selector(warp_selector), .read_en_0(read_en_0), .read_en_1(read_en_1),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .write_en(write_en), .waddr(waddr),
    .wdata(wdata), .rdata_0(rdata_0), .rdata_1(rdata_1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1)
  );

  always #5 clk = ~clk;

  // Behavioural block: per-lane write at the rising edge, combinational read
  logic [LANES-1:0] mem [NW][NP];
  always @(posedge clk) begin
    if (|write_en)
      mem[warp_selector][waddr] <= (mem[warp_selector][waddr] & ~write_en) | (wdata & write_en);
  end
  assign rdata_0 = mem[warp_selector][raddr_0] & read_en_0;
  assign rdata_1 = mem[warp_selector][raddr_1] & read_en_1;

  task automatic set_req(input int r, input logic wr, input logic [WW-1:0] w,
                         input logic [AW-1:0] a, input logic [LANES-1:0] m,
                         input logic [LANES-1:0] d);
    req_valid[r]                  = 1'b1;
    req_is_write[r]               = wr;
    req_warp[r*WW +: WW]          = w;
    req_raddr_0[r*AW +: AW]       = a;
    req_raddr_1[r*AW +: AW]       = a;
    req_waddr[r*AW +: AW]         = a;
    req_lane_mask[r*LANES +: LANES] = m;
    req_wdata[r*LANES +: LANES]   = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #12;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_vec++; if (read_en_0 !== 16'h0 || read_en_1 !== 16'h0) begin n_err++; $display("FAIL rst_read_en: got %h/%h want 0", read_en_0, read_en_1); end
    n_vec++; if (write_en !== 16'h0) begin n_err++; $display("FAIL rst_write_en: got %h want 0", write_en); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL rst_rsp: got %b/%0d want 0/0", rsp_valid, rsp_id); end
    n_vec++; if (warp_selector !== 3'd0 || waddr !== 5'd0 || wdata !== 16'h0) begin n_err++; $display("FAIL rst_issue: got %0d/%0d/%h want 0", warp_selector, waddr, wdata); end
    req_valid = '0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 3'd3, 5'h07, 16'hFFFF, 16'hA5A5);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_ready: got %b want 0001", req_ready); end
    next_cycle();
    set_req(0, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    #1;
    n_vec++; if (write_en !== 16'hFFFF || read_en_0 !== 16'h0) begin n_err++; $display("FAIL wr_issue_en: got we=%h re=%h want FFFF/0000", write_en, read_en_0); end
    n_vec++; if (warp_selector !== 3'd3 || waddr !== 5'h07 || wdata !== 16'hA5A5) begin n_err++; $display("FAIL wr_issue_data: got %0d/%h/%h want 3/07/A5A5", warp_selector, waddr, wdata); end
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_ready: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    #1;
    n_vec++; if (read_en_0 !== 16'hFFFF || read_en_1 !== 16'hFFFF || write_en !== 16'h0) begin n_err++; $display("FAIL rd_issue_en: got %h/%h/%h want FFFF/FFFF/0000", read_en_0, read_en_1, write_en); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); end
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL rd_rsp: got %b/%0d want 1/0", rsp_valid, rsp_id); end
    n_vec++; if (rsp_rdata_0 !== 16'hA5A5 || rsp_rdata_1 !== 16'hA5A5) begin n_err++; $display("FAIL rd_data: got %h/%h want A5A5/A5A5", rsp_rdata_0, rsp_rdata_1); end
    n_vec++; if (read_en_0 !== 16'h0) begin n_err++; $display("FAIL idle_read_en: got %h want 0", read_en_0); end
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_rdy;
    pulse_reset();
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      if (k >= 2) begin
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4) || rsp_rdata_0 !== 16'hA5A5) begin
          n_err++; $display("FAIL rr_rsp[%0d]: got %b/%0d/%h want 1/%0d/A5A5", k, rsp_valid, rsp_id, rsp_rdata_0, (k - 2) % 4);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    // rr_ptr is 0 here; req2 write then req1 read on the following cycle
    set_req(2, 1'b1, 3'd1, 5'h1F, 16'hFFFF, 16'h00FF);
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL b2b_wr_ready: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    set_req(1, 1'b0, 3'd1, 5'h1F, 16'hFFFF, 16'h0000);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL b2b_rd_ready: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    #1;
    n_vec++; if (warp_selector !== 3'd1 || raddr_0 !== 5'h1F || raddr_1 !== 5'h1F) begin n_err++; $display("FAIL b2b_issue: got %0d/%h/%h want 1/1F/1F", warp_selector, raddr_0, raddr_1); end
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rdata_0 !== 16'h00FF) begin n_err++; $display("FAIL b2b_rsp: got %b/%0d/%h want 1/1/00FF", rsp_valid, rsp_id, rsp_rdata_0); end
    next_cycle();
  endtask

  task automatic test_mask();
    // rr_ptr is 2; req3 is the only requester throughout
    set_req(3, 1'b1, 3'd2, 5'h04, 16'hFFFF, 16'hFFFF);
    next_cycle();
    set_req(3, 1'b0, 3'd2, 5'h04, 16'h000F, 16'h0000);
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mask_ready: got %b want 1000", req_ready); end
    next_cycle();
    set_req(3, 1'b0, 3'd2, 5'h04, 16'h0000, 16'h0000);
    next_cycle();
    req_valid = '0;
    #1;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata_0 !== 16'h000F || rsp_rdata_1 !== 16'h000F) begin n_err++; $display("FAIL mask_0F: got %b/%h/%h want 1/000F/000F", rsp_valid, rsp_rdata_0, rsp_rdata_1); end
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rdata_0 !== 16'h0000 || rsp_rdata_1 !== 16'h0000) begin n_err++; $display("FAIL mask_zero: got %b/%0d/%h/%h want 1/3/0/0", rsp_valid, rsp_id, rsp_rdata_0, rsp_rdata_1); end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    set_req(0, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    next_cycle();
    req_valid = '0;
    #1;
    n_vec++; if (read_en_0 !== 16'hFFFF) begin n_err++; $display("FAIL mid_issue: got %h want FFFF", read_en_0); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (read_en_0 !== 16'h0 || read_en_1 !== 16'h0 || write_en !== 16'h0) begin n_err++; $display("FAIL mid_en_clear: got %h/%h/%h want 0", read_en_0, read_en_1, write_en); end
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_drop: got %b want 0", rsp_valid); end
    rst_n = 1'b1;
    set_req(0, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    set_req(1, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL mid_after_rsp: got %b/%0d want 1/0", rsp_valid, rsp_id); end
    next_cycle();
  endtask

  task automatic test_write_prio();
    logic [NUM_REQ-1:0] first_rdy, second_rdy;
`ifdef PRED_ARB_WRITE_PRIO_EN
    first_rdy  = 4'b1000;
    second_rdy = 4'b0001;
`else
    first_rdy  = 4'b0001;
    second_rdy = 4'b1000;
`endif
    pulse_reset();
    set_req(0, 1'b0, 3'd3, 5'h07, 16'hFFFF, 16'h0000);
    set_req(3, 1'b1, 3'd5, 5'h02, 16'hFFFF, 16'h1234);
    #1;
    n_vec++; if (req_ready !== first_rdy) begin n_err++; $display("FAIL prio_first: got %b want %b", req_ready, first_rdy); end
    next_cycle();
    req_valid = req_valid & ~first_rdy;
    #1;
    n_vec++; if (req_ready !== second_rdy) begin n_err++; $display("FAIL prio_second: got %b want %b", req_ready, second_rdy); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_mask();
    test_reset_midflight();
    test_write_prio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pred_reg_arbiter.md
Name: pred_reg_arbiter

Overview:
- Shares one predicate_register_block (2 read ports, 1 write port, single warp_selector) among NUM_REQ requesters, e.g. issue, branch unit and predicate-writeback.
- Round-robin arbitration with valid/ready handshake.
- Drives the block's warp_selector, enables, addresses and write data from registered outputs, then returns read data with fixed latency.
- Throughput: one access per cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LANES, 16, lanes per warp (width of enables/data)
NUM_WARPS, 8, warps; warp id width WW = clog2(NUM_WARPS) = 3
NUM_PREGS, 32, predicate registers per lane; address width AW = clog2 = 5

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant; transfer on valid&ready
req_is_write  in  NUM_REQ  1 = write, 0 = dual read
req_warp  in  NUM_REQ*WW  target warp
req_raddr_0  in  NUM_REQ*AW  read address, port 0
req_raddr_1  in  NUM_REQ*AW  read address, port 1
req_waddr  in  NUM_REQ*AW  write address
req_lane_mask  in  NUM_REQ*LANES  lanes to read/write
req_wdata  in  NUM_REQ*LANES  write bit per lane
warp_selector  out  WW  to block
read_en_0, read_en_1  out  LANES each  to block
raddr_0, raddr_1  out  AW each  to block
write_en  out  LANES  to block
waddr  out  AW  to block
wdata  out  LANES  to block, bit i -> wdata_i
rdata_0, rdata_1  in  LANES each  from block, bit i = rdata_p_i (combinational in block)
rsp_valid  out  1  read response valid (no backpressure)
rsp_id  out  clog2(NUM_REQ)  requester index of response
rsp_rdata_0, rsp_rdata_1  out  LANES each  read result, masked

Behaviour:
- Reset (async assert, sync deassert by consumer convention): all outputs 0; rr_ptr=0; in-flight issue and response dropped.
- Cycle N (arbitrate, combinational): the first valid requester at or after rr_ptr (wrapping at NUM_REQ) gets req_ready=1. Only one grant per cycle. No valid request means req_ready=0 and no pointer change.
- On grant: rr_ptr <= winner+1 mod NUM_REQ. req_ready does not depend on rsp (no stalls).
- Cycle N+1 (issue, registered outputs): warp_selector, addresses and wdata are taken from the winner.
  - Read: read_en_0 = read_en_1 = lane_mask, write_en = 0.
  - Write: write_en = lane_mask, read_en_* = 0; the block writes at the rising edge ending N+1.
  - Idle cycle: all enables 0. Addresses, warp and wdata hold their last values.
- End of N+1 (reads only): capture rdata_0/1 ANDed with the issued lane_mask.
- Cycle N+2: rsp_valid=1 for exactly one cycle with rsp_id = winner. Read latency is 2 cycles from handshake.
- Writes produce no response.
- Read-after-write to the same warp/addr granted the next cycle sees the new data: the write commits before the read issue cycle, so no forwarding is needed.
- Write with lane_mask=0 consumes a slot and writes nothing. Read with mask=0 returns zeros with rsp_valid=1.
- Simultaneous read and write are serialized by arbitration; the block's ports are never shared in one cycle.
- Out-of-range req_warp (>= NUM_WARPS, non-power-of-2 case) is passed through unchanged; the requester must not issue it.

Optional Feature:
- PRED_ARB_WRITE_PRIO_EN defined: any valid write request beats all reads. Among writes, round-robin from rr_ptr. rr_ptr updates only on read grants, so reads keep their fairness order.
- Undefined: pure round-robin across all requests regardless of type.

Test Plan:
- Reset, then req0 writes warp 3, addr 5'h07, mask 16'hFFFF, wdata 16'hA5A5. Then req0 reads warp 3, raddr_0=raddr_1=5'h07, mask 16'hFFFF -> rsp_valid 2 cycles after the read handshake, rsp_id=0, rsp_rdata_0=rsp_rdata_1=16'hA5A5.
- All 4 requesters hold valid reads continuously -> grants 0,1,2,3,0,... one per cycle; rsp_id follows the same sequence 2 cycles later.
- Back-to-back write (req2: warp 1, addr 5'h1F, wdata 16'h00FF) then read (req1, same warp/addr) on the next cycle -> rsp_rdata_0 = 16'h00FF.
- Read with mask 16'h000F of a register holding 16'hFFFF -> rsp_rdata_0 = 16'h000F. Read with mask 0 -> 16'h0000, rsp_valid still 1.
- Assert rst_n=0 while a read is in the issue cycle -> rsp_valid stays 0, all block enables 0 immediately, and after release the first grant goes to req0.
- With PRED_ARB_WRITE_PRIO_EN: req0 read and req3 write valid together with rr_ptr=0 -> req3 granted first, req0 next cycle. Without the macro: req0 is granted first.
